lcd_ctrl: RTL and testbench
===========================

LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2: cycles RS/RW/DATA are stable before EN rises.
REQ-002 SHALL have parameter EN_HIGH_CYC, default 12: EN high-pulse width in cycles.
REQ-003 SHALL have parameter HOLD_CYC, default 2: cycles RS/RW/DATA are held after EN falls.
REQ-004 SHALL have parameter CMD_WAIT_CYC, default 2000: post-transfer wait for normal command/data.
REQ-005 SHALL have parameter CLR_WAIT_CYC, default 82000: post-transfer wait for clear (0x01) / home (0x02) commands.
REQ-006 SHALL have parameter INIT_WAIT_CYC, default 750000: power-on wait after reset release.
REQ-007 Ports SHALL be:
  i_clk         in   1   clock, rising edge; one clock; reset is asynchronous and active-high.
  i_reset       in   1   asynchronous reset, active high.
  i_lcd_word    in   32  LCD word from LSU store: [31]=ON, [9]=RS, [7:0]=DATA; other bits ignored.
  i_lcd_valid   in   1   one-cycle store strobe for i_lcd_word.
  o_lcd_ready   out  1   holding buffer can accept a word.
  o_lcd_busy    out  1   init or transfer in progress, or buffer full.
  o_lcd_data    out  8   LCD DB[7:0].
  o_lcd_rs      out  1   LCD register select.
  o_lcd_rw      out  1   LCD R/W, constant 0.
  o_lcd_en      out  1   LCD enable strobe.
  o_lcd_on      out  1   LCD power/backlight enable.

Function
REQ-008 SHALL accept a word when i_lcd_valid && o_lcd_ready, storing it in a one-entry holding buffer.
REQ-009 SHALL silently drop i_lcd_valid when o_lcd_ready=0; buffer contents remain unchanged.
REQ-010 o_lcd_ready SHALL be 1 only when init is complete and the buffer is empty.
REQ-011 o_lcd_on SHALL update to word[31] on the clock edge of acceptance.
REQ-012 FSM states SHALL be: PWR_WAIT, INIT_LOAD, IDLE, SETUP, PULSE, HOLD, WAIT.
REQ-013 PWR_WAIT SHALL last exactly INIT_WAIT_CYC cycles, then go to INIT_LOAD.
REQ-014 Init SHALL send RS=0 commands 0x38, 0x0C, 0x01, 0x06 in order, each as a full transfer (REQ-016..019); after the last WAIT, go to IDLE and set init_done.
REQ-015 IDLE with buffer full SHALL load RS/DATA from the buffer into outputs, empty the buffer, and enter SETUP on the same edge; IDLE with buffer empty SHALL stay in IDLE.
REQ-016 SETUP SHALL last SETUP_CYC cycles with o_lcd_en=0, then go to PULSE.
REQ-017 PULSE SHALL last EN_HIGH_CYC cycles with o_lcd_en=1, then go to HOLD.
REQ-018 HOLD SHALL last HOLD_CYC cycles with o_lcd_en=0, then go to WAIT.
REQ-019 WAIT SHALL last CLR_WAIT_CYC cycles if RS=0 and DATA is 0x01 or 0x02, otherwise CMD_WAIT_CYC, then go to IDLE (or INIT_LOAD during init).
REQ-020 o_lcd_data and o_lcd_rs SHALL remain constant from SETUP entry through WAIT exit.
REQ-021 The buffer SHALL accept a new word while a transfer is in progress (buffer empty); back-to-back transfers SHALL incur no gap beyond the IDLE cycle.
REQ-022 Phase counters SHALL be 32 bits wide, reload on each state entry, and never wrap within a phase.
REQ-023 o_lcd_busy SHALL equal !(state==IDLE && buffer empty && init_done).
REQ-024 Parameters set to 0 SHALL be treated as 1.

Reset
REQ-025 Asserting i_reset at any time, including mid-transfer, SHALL immediately set: state=PWR_WAIT, buffer empty, init_done=0, o_lcd_en=0, o_lcd_data=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_on=0, o_lcd_ready=0, o_lcd_busy=1.
REQ-026 After reset release, the full power-on and init sequence SHALL restart.

Verification (params SETUP=1, EN_HIGH=2, HOLD=1, CMD_WAIT=4, CLR_WAIT=10, INIT_WAIT=8)
REQ-027 Release reset -> ready=0 for 8 cycles; then four EN pulses with DATA 0x38, 0x0C, 0x01, 0x06, RS=0; 8-cycle spacing, except 14 cycles after 0x01; then ready=1 and busy=0.
REQ-028 After init, store 0x8000_0241 -> on=1; RS=1, DATA=0x41; EN high exactly 2 cycles, 1 cycle after SETUP entry; busy clears 8 cycles after SETUP entry.
REQ-029 Two back-to-back stores 0x241, 0x242 with valid one cycle apart -> both transfers occur in order; no word is lost.
REQ-030 Three stores during one transfer -> second accepted, third dropped (ready=0); only two transfers appear.
REQ-031 Store 0x001 (clear) -> WAIT lasts 10 cycles; store 0x003 -> WAIT lasts 4 cycles.
REQ-032 Assert reset during PULSE -> en=0, on=0, ready=0 in the same cycle; full init repeats after release.

Source files
------------

// File: rtl/lcd_ctrl_if.sv
// rtl/lcd_ctrl_if.sv - store-side and LCD pin bundle for lcd_ctrl
interface lcd_ctrl_if;
   logic [31:0] i_lcd_word;
   logic        i_lcd_valid;
   logic        o_lcd_ready;
   logic        o_lcd_busy;
   logic [7:0]  o_lcd_data;
   logic        o_lcd_rs;
   logic        o_lcd_rw;
   logic        o_lcd_en;
   logic        o_lcd_on;

   modport slave (
      input  i_lcd_word, i_lcd_valid,
      output o_lcd_ready, o_lcd_busy, o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on
   );

   modport master (
      output i_lcd_word, i_lcd_valid,
      input  o_lcd_ready, o_lcd_busy, o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on
   );
endinterface

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780-style LCD write sequencer with one-entry holding buffer
module lcd_ctrl #(
   parameter int unsigned SETUP_CYC     = 2,
   parameter int unsigned EN_HIGH_CYC   = 12,
   parameter int unsigned HOLD_CYC      = 2,
   parameter int unsigned CMD_WAIT_CYC  = 2000,
   parameter int unsigned CLR_WAIT_CYC  = 82000,
   parameter int unsigned INIT_WAIT_CYC = 750000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   lcd_ctrl_if.slave  lcd
);

   // Reload values are length-1 so a phase ends on the cycle its counter reads zero;
   // a zero length behaves like one.
   localparam logic [31:0] SETUP_LD = (SETUP_CYC     == 0) ? 32'd0 : 32'(SETUP_CYC - 1);
   localparam logic [31:0] EN_LD    = (EN_HIGH_CYC   == 0) ? 32'd0 : 32'(EN_HIGH_CYC - 1);
   localparam logic [31:0] HOLD_LD  = (HOLD_CYC      == 0) ? 32'd0 : 32'(HOLD_CYC - 1);
   localparam logic [31:0] CMD_LD   = (CMD_WAIT_CYC  == 0) ? 32'd0 : 32'(CMD_WAIT_CYC - 1);
   localparam logic [31:0] CLR_LD   = (CLR_WAIT_CYC  == 0) ? 32'd0 : 32'(CLR_WAIT_CYC - 1);
   localparam logic [31:0] INIT_LD  = (INIT_WAIT_CYC == 0) ? 32'd0 : 32'(INIT_WAIT_CYC - 1);

   typedef enum logic [2:0] {
      PWR_WAIT,
      INIT_LOAD,
      IDLE,
      SETUP,
      PULSE,
      HOLD,
      WAIT
   } state_t;

   state_t      state;
   logic [31:0] cnt;
   logic        buf_full;
   logic        buf_rs;
   logic [7:0]  buf_data;
   logic        init_done;
   logic [1:0]  init_idx;
   logic [7:0]  data_q;
   logic        rs_q;
   logic        en_q;
   logic        on_q;
   logic        ready;
   logic        unused_word_bits;

   // Power-on command sequence: 8-bit 2-line, display on, clear, entry mode increment.
   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    init_cmd = 8'h38;
         2'd1:    init_cmd = 8'h0C;
         2'd2:    init_cmd = 8'h01;
         default: init_cmd = 8'h06;
      endcase
   endfunction

   // Clear and return-home need the long settle time.
   function automatic logic is_slow(input logic rs, input logic [7:0] d);
      is_slow = !rs && (d == 8'h01 || d == 8'h02);
   endfunction

   assign ready            = init_done && !buf_full;
   assign unused_word_bits = ^{lcd.i_lcd_word[30:10], lcd.i_lcd_word[8]};

   // Buffer capture and the transfer sequencer share one register block.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state     <= PWR_WAIT;
         cnt       <= INIT_LD;
         buf_full  <= 1'b0;
         buf_rs    <= 1'b0;
         buf_data  <= 8'h00;
         init_done <= 1'b0;
         init_idx  <= 2'd0;
         data_q    <= 8'h00;
         rs_q      <= 1'b0;
         en_q      <= 1'b0;
         on_q      <= 1'b0;
      end else begin
         // Capture only when empty, so this never collides with the IDLE drain below.
         if (lcd.i_lcd_valid && ready) begin
            buf_full <= 1'b1;
            buf_rs   <= lcd.i_lcd_word[9];
            buf_data <= lcd.i_lcd_word[7:0];
            on_q     <= lcd.i_lcd_word[31];
         end

         case (state)
            PWR_WAIT: begin
               if (cnt == '0) state <= INIT_LOAD;
               else           cnt   <= cnt - 32'd1;
            end
            INIT_LOAD: begin
               data_q <= init_cmd(init_idx);
               rs_q   <= 1'b0;
               cnt    <= SETUP_LD;
               state  <= SETUP;
            end
            IDLE: begin
               if (buf_full) begin
                  data_q   <= buf_data;
                  rs_q     <= buf_rs;
                  buf_full <= 1'b0;
                  cnt      <= SETUP_LD;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == '0) begin
                  en_q  <= 1'b1;
                  cnt   <= EN_LD;
                  state <= PULSE;
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            PULSE: begin
               if (cnt == '0) begin
                  en_q  <= 1'b0;
                  cnt   <= HOLD_LD;
                  state <= HOLD;
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            HOLD: begin
               if (cnt == '0) begin
                  cnt   <= is_slow(rs_q, data_q) ? CLR_LD : CMD_LD;
                  state <= WAIT;
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  if (init_done) begin
                     state <= IDLE;
                  end else if (init_idx == 2'd3) begin
                     init_done <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     // Next init command goes out on this edge so init transfers run back-to-back.
                     init_idx <= 2'(init_idx + 2'd1);
                     data_q   <= init_cmd(2'(init_idx + 2'd1));
                     rs_q     <= 1'b0;
                     cnt      <= SETUP_LD;
                     state    <= SETUP;
                  end
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            default: begin
               state <= PWR_WAIT;
               cnt   <= INIT_LD;
            end
         endcase
      end
   end

   assign lcd.o_lcd_ready = ready;
   assign lcd.o_lcd_busy  = !(state == IDLE && !buf_full && init_done);
   assign lcd.o_lcd_data  = data_q;
   assign lcd.o_lcd_rs    = rs_q;
   assign lcd.o_lcd_rw    = 1'b0;
   assign lcd.o_lcd_en    = en_q;
   assign lcd.o_lcd_on    = on_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - directed self-checking bench for lcd_ctrl
module tb_lcd_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   typedef struct {
      int         rise;
      int         fall;
      logic [7:0] data;
      logic       rs;
   } ev_t;

   ev_t  evq[$];
   int   rise_cyc = 0;
   logic en_prev = 1'b0;

   lcd_ctrl_if lcd();

   lcd_ctrl #(
      .SETUP_CYC(1), .EN_HIGH_CYC(2), .HOLD_CYC(1),
      .CMD_WAIT_CYC(4), .CLR_WAIT_CYC(10), .INIT_WAIT_CYC(8)
   ) dut (
      .i_clk(clk),
      .i_reset(rst),
      .lcd(lcd)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Log every EN pulse with its edges and the bus contents.
   always @(negedge clk) begin
      if (lcd.o_lcd_en && !en_prev) rise_cyc = cyc;
      if (!lcd.o_lcd_en && en_prev) begin
         ev_t e;
         e.rise = rise_cyc;
         e.fall = cyc;
         e.data = lcd.o_lcd_data;
         e.rs   = lcd.o_lcd_rs;
         evq.push_back(e);
      end
      en_prev = lcd.o_lcd_en;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] w);
      lcd.i_lcd_word  = w;
      lcd.i_lcd_valid = 1'b1;
      step();
      lcd.i_lcd_valid = 1'b0;
   endtask

   task automatic wait_idle(output int t);
      int n = 0;
      while (lcd.o_lcd_busy && n < 200) begin
         step();
         n++;
      end
      check("idle_timeout", 32'(lcd.o_lcd_busy), 32'd0);
      t = cyc;
   endtask

   task automatic run_init(input string tag);
      logic [7:0] exp_cmd [4];
      int         exp_gap [3];
      int         r;
      int         bad = 0;
      int         n = 0;
      exp_cmd = '{8'h38, 8'h0C, 8'h01, 8'h06};
      exp_gap = '{8, 8, 14};
      evq.delete();
      rst = 1'b0;
      r   = cyc;
      repeat (8) begin
         step();
         if (lcd.o_lcd_ready) bad++;
      end
      check({tag, "_pwr_ready"}, 32'(bad), 32'd0);
      while (evq.size() < 4 && n < 200) begin
         step();
         n++;
      end
      check({tag, "_pulse_count"}, 32'(evq.size()), 32'd4);
      if (evq.size() >= 4) begin
         check({tag, "_first_rise"}, 32'(evq[0].rise - r), 32'd10);
         for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_data%0d", tag, i), 32'(evq[i].data), 32'(exp_cmd[i]));
            check($sformatf("%s_rs%0d", tag, i), 32'(evq[i].rs), 32'd0);
            check($sformatf("%s_width%0d", tag, i), 32'(evq[i].fall - evq[i].rise), 32'd2);
         end
         for (int i = 0; i < 3; i++)
            check($sformatf("%s_gap%0d", tag, i), 32'(evq[i+1].rise - evq[i].rise), 32'(exp_gap[i]));
      end
      n = 0;
      while (!lcd.o_lcd_ready && n < 100) begin
         step();
         n++;
      end
      check({tag, "_ready_time"}, 32'(cyc - r), 32'd47);
      check({tag, "_busy_after"}, 32'(lcd.o_lcd_busy), 32'd0);
   endtask

   initial begin
      int a;
      int t;
      int n;
      logic [31:0] wait_word [4];
      int          wait_exp  [4];
      wait_word = '{32'h001, 32'h003, 32'h202, 32'h002};
      wait_exp  = '{11, 5, 5, 11};

      lcd.i_lcd_word  = '0;
      lcd.i_lcd_valid = 1'b0;

      // Reset state
      step();
      step();
      check("rst_ready", 32'(lcd.o_lcd_ready), 32'd0);
      check("rst_busy",  32'(lcd.o_lcd_busy),  32'd1);
      check("rst_en",    32'(lcd.o_lcd_en),    32'd0);
      check("rst_on",    32'(lcd.o_lcd_on),    32'd0);
      check("rst_data",  32'(lcd.o_lcd_data),  32'd0);
      check("rst_rs",    32'(lcd.o_lcd_rs),    32'd0);
      check("rst_rw",    32'(lcd.o_lcd_rw),    32'd0);

      run_init("init");

      // Single data write with backlight on
      evq.delete();
      store(32'h8000_0241);
      a = cyc;
      check("w1_on",    32'(lcd.o_lcd_on),    32'd1);
      check("w1_ready", 32'(lcd.o_lcd_ready), 32'd0);
      wait_idle(t);
      check("w1_busy_clear", 32'(t - a), 32'd9);
      check("w1_count", 32'(evq.size()), 32'd1);
      if (evq.size() >= 1) begin
         check("w1_rise",  32'(evq[0].rise - a), 32'd2);
         check("w1_width", 32'(evq[0].fall - evq[0].rise), 32'd2);
         check("w1_data",  32'(evq[0].data), 32'h41);
         check("w1_rs",    32'(evq[0].rs), 32'd1);
      end

      // Back-to-back stores one cycle apart
      evq.delete();
      store(32'h241);
      step();
      check("b2b_ready", 32'(lcd.o_lcd_ready), 32'd1);
      store(32'h242);
      check("b2b_on", 32'(lcd.o_lcd_on), 32'd0);
      wait_idle(t);
      check("b2b_count", 32'(evq.size()), 32'd2);
      if (evq.size() >= 2) begin
         check("b2b_data0", 32'(evq[0].data), 32'h41);
         check("b2b_data1", 32'(evq[1].data), 32'h42);
         check("b2b_spacing", 32'(evq[1].rise - evq[0].rise), 32'd9);
      end

      // Third store while buffer full is dropped
      evq.delete();
      store(32'h241);
      step();
      store(32'h242);
      check("drop_ready", 32'(lcd.o_lcd_ready), 32'd0);
      store(32'h243);
      wait_idle(t);
      check("drop_count", 32'(evq.size()), 32'd2);
      if (evq.size() >= 2) begin
         check("drop_data0", 32'(evq[0].data), 32'h41);
         check("drop_data1", 32'(evq[1].data), 32'h42);
      end

      // WAIT length: hold(1) + wait, measured from EN fall to busy clear
      for (int i = 0; i < 4; i++) begin
         evq.delete();
         store(wait_word[i]);
         wait_idle(t);
         check($sformatf("wait_count%0d", i), 32'(evq.size()), 32'd1);
         if (evq.size() >= 1)
            check($sformatf("wait_len%0d", i), 32'(t - evq[0].fall), 32'(wait_exp[i]));
      end

      // Reset in the middle of an EN pulse
      store(32'h8000_0241);
      n = 0;
      while (!lcd.o_lcd_en && n < 20) begin
         step();
         n++;
      end
      check("mid_en_seen", 32'(lcd.o_lcd_en), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_en",    32'(lcd.o_lcd_en),    32'd0);
      check("mid_rst_on",    32'(lcd.o_lcd_on),    32'd0);
      check("mid_rst_ready", 32'(lcd.o_lcd_ready), 32'd0);
      check("mid_rst_busy",  32'(lcd.o_lcd_busy),  32'd1);
      check("mid_rst_data",  32'(lcd.o_lcd_data),  32'd0);
      step();
      run_init("reinit");

      evq.delete();
      store(32'h242);
      wait_idle(t);
      check("post_count", 32'(evq.size()), 32'd1);
      if (evq.size() >= 1) check("post_data", 32'(evq[0].data), 32'h42);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
